// File: rtl/mem_pkg.sv
// mem_pkg: definitions shared by the memory request controller and the latch array top.
//   - Default geometry: MEM_WORDS, MEM_AW, MEM_DW.
//   - Opcode encoding: OP_READ, OP_WRITE.
//   - Controller FSM state type (7 states, 3-bit encoding).
// Optional feature macro used by the controller: MEM_REQ_ADDR_CHECK_EN.
package mem_pkg;

    localparam int unsigned MEM_WORDS = 6;
    localparam int unsigned MEM_AW    = 3;
    localparam int unsigned MEM_DW    = 8;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWSetup = 3'd1,
        StWPulse = 3'd2,
        StWHold  = 3'd3,
        StRSel   = 3'd4,
        StRCapt  = 3'd5,
        StResp   = 3'd6
    } mem_state_e;

endpackage

// File: rtl/mem_addr_dec.sv
// mem_addr_dec: combinational word-address to one-hot word-select decoder.
// Ports:
//   addr_i      in  AW     word address
//   sel_o       out WORDS  one-hot select; all zero when the address is out of range
//   in_range_o  out 1      address < WORDS
module mem_addr_dec
    import mem_pkg::*;
#(
    parameter int unsigned WORDS = MEM_WORDS,
    parameter int unsigned AW    = MEM_AW
) (
    input  logic [AW-1:0]    addr_i,
    output logic [WORDS-1:0] sel_o,
    output logic             in_range_o
);

    always_comb begin
        sel_o = '0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            sel_o[i] = (32'(addr_i) == i);
        end
    end

    assign in_range_o = (32'(addr_i) < WORDS);

endmodule

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: request-side controller for the latch-based memory word array.
// Accepts one read or write per valid/ready handshake, drives a registered one-hot word
// select, and sequences the latch write enable through setup / pulse / hold phases so the
// transparent latches never see a glitching enable. Read data from the array is active-low
// and is inverted on capture.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake; req_op (1=write), req_addr, req_wdata
//   resp_valid/resp_ready      response handshake; resp_rdata (0 for writes), resp_err
//   arr_sel, arr_we, arr_wdata registered array controls (latch enable = arr_we & arr_sel[i])
//   arr_rdata_n                per-word inverted array data, unselected words read all-ones
// Optional feature: define MEM_REQ_ADDR_CHECK_EN to answer out-of-range accesses
// immediately with resp_err=1; otherwise resp_err is tied low.
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned WORDS = MEM_WORDS,
    parameter int unsigned AW    = MEM_AW,
    parameter int unsigned DW    = MEM_DW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_op,
    input  logic [AW-1:0]       req_addr,
    input  logic [DW-1:0]       req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DW-1:0]       resp_rdata,
    output logic                resp_err,
    output logic [WORDS-1:0]    arr_sel,
    output logic                arr_we,
    output logic [DW-1:0]       arr_wdata,
    input  logic [WORDS*DW-1:0] arr_rdata_n
);

    mem_state_e       state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WORDS-1:0] sel_q, sel_d;
    logic             we_q, we_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
`ifdef MEM_REQ_ADDR_CHECK_EN
    logic             err_q, err_d;
`endif

    logic [WORDS-1:0] dec_sel;
    logic             dec_in_range;
    logic             accept;
    logic [DW-1:0]    rd_word_n;

    mem_addr_dec #(
        .WORDS (WORDS),
        .AW    (AW)
    ) u_addr_dec (
        .addr_i     (req_addr),
        .sel_o      (dec_sel),
        .in_range_o (dec_in_range)
    );

    assign req_ready = (state_q == StIdle) && !reset;
    assign accept    = req_valid && req_ready;

    // Word mux on the registered address; an out-of-range address sees the idle all-ones
    // bus, which inverts to zero.
    always_comb begin
        rd_word_n = '1;
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (32'(addr_q) == i) begin
                rd_word_n = arr_rdata_n[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        we_d     = 1'b0;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
`ifdef MEM_REQ_ADDR_CHECK_EN
        err_d    = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d  = req_addr;
                    sel_d   = dec_in_range ? dec_sel : '0;
                    state_d = (req_op == OP_WRITE) ? StWSetup : StRSel;
                    wdata_d = (req_op == OP_WRITE) ? req_wdata : '0;
`ifdef MEM_REQ_ADDR_CHECK_EN
                    // Bad address: skip the array entirely and answer next cycle.
                    if (!dec_in_range) begin
                        state_d  = StResp;
                        sel_d    = '0;
                        wdata_d  = '0;
                        rdata_d  = '0;
                        rvalid_d = 1'b1;
                        err_d    = 1'b1;
                    end
`endif
                end
            end
            StWSetup: begin
                state_d = StWPulse;
                we_d    = 1'b1;
            end
            StWPulse: begin
                state_d = StWHold;
            end
            StWHold: begin
                state_d  = StResp;
                sel_d    = '0;
                wdata_d  = '0;
                rdata_d  = '0;
                rvalid_d = 1'b1;
            end
            StRSel: begin
                state_d = StRCapt;
            end
            StRCapt: begin
                state_d  = StResp;
                sel_d    = '0;
                rdata_d  = ~rd_word_n;
                rvalid_d = 1'b1;
            end
            StResp: begin
                if (resp_ready) begin
                    state_d  = StIdle;
                    rvalid_d = 1'b0;
                    rdata_d  = '0;
`ifdef MEM_REQ_ADDR_CHECK_EN
                    err_d    = 1'b0;
`endif
                end
            end
            default: begin
                state_d  = StIdle;
                sel_d    = '0;
                wdata_d  = '0;
                rdata_d  = '0;
                rvalid_d = 1'b0;
`ifdef MEM_REQ_ADDR_CHECK_EN
                err_d    = 1'b0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
`ifdef MEM_REQ_ADDR_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
`ifdef MEM_REQ_ADDR_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    // All array controls come straight from flops so the latch enables cannot glitch.
    assign arr_sel    = sel_q;
    assign arr_we     = we_q;
    assign arr_wdata  = wdata_q;
    assign resp_valid = rvalid_q;
    assign resp_rdata = rdata_q;
`ifdef MEM_REQ_ADDR_CHECK_EN
    assign resp_err   = err_q;
`else
    assign resp_err   = 1'b0;
`endif

    // Write enable may only be high while the FSM sits in the pulse phase.
    a_we_only_in_pulse: assert property (@(posedge clk) disable iff (reset)
        we_q |-> (state_q == StWPulse));
    a_sel_onehot0: assert property (@(posedge clk) disable iff (reset)
        $onehot0(sel_q));

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: directed self-checking bench for mem_req_ctrl with a behavioural latch
// array model. Build with MEM_REQ_ADDR_CHECK_EN defined to exercise the address-check path.
module tb_mem_req_ctrl;

    localparam int unsigned WORDS = 6;
    localparam int unsigned AW    = 3;
    localparam int unsigned DW    = 8;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic                req_op = 1'b0;
    logic [AW-1:0]       req_addr = '0;
    logic [DW-1:0]       req_wdata = '0;
    logic                resp_valid;
    logic                resp_ready = 1'b1;
    logic [DW-1:0]       resp_rdata;
    logic                resp_err;
    logic [WORDS-1:0]    arr_sel;
    logic                arr_we;
    logic [DW-1:0]       arr_wdata;
    logic [WORDS*DW-1:0] arr_rdata_n;

    logic [DW-1:0] mem [WORDS] = '{default: '0};

    int n_chk = 0;
    int n_bad = 0;

    mem_req_ctrl #(
        .WORDS (WORDS),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .arr_sel     (arr_sel),
        .arr_we      (arr_we),
        .arr_wdata   (arr_wdata),
        .arr_rdata_n (arr_rdata_n)
    );

    always #5 clk = ~clk;

    // Array model: latch is transparent while arr_we & arr_sel[i]; mid-cycle capture suffices.
    always @(negedge clk) begin
        for (int i = 0; i < int'(WORDS); i++) begin
            if (arr_we && arr_sel[i]) mem[i] = arr_wdata;
        end
    end

    always_comb begin
        arr_rdata_n = '1;
        for (int i = 0; i < int'(WORDS); i++) begin
            if (arr_sel[i]) arr_rdata_n[i*DW +: DW] = ~mem[i];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WORDS-1:0] sel_of(input logic [AW-1:0] a);
        logic [WORDS-1:0] s;
        s = '0;
        if (32'(a) < WORDS) s[a] = 1'b1;
        return s;
    endfunction

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid  = 1'b1;
        req_op     = 1'b1;
        req_addr   = a;
        req_wdata  = d;
        resp_ready = 1'b1;
        check_eq("w_req_ready", 32'(req_ready), 1);
        tick();
        req_valid = 1'b0;
        req_wdata = '0;
`ifdef MEM_REQ_ADDR_CHECK_EN
        if (32'(a) >= WORDS) begin
            check_eq("w_err_valid", 32'(resp_valid), 1);
            check_eq("w_err_flag", 32'(resp_err), 1);
            check_eq("w_err_sel", 32'(arr_sel), 0);
            check_eq("w_err_rdata", 32'(resp_rdata), 0);
            tick();
            check_eq("w_err_done", 32'(resp_valid), 0);
            return;
        end
`endif
        check_eq("w1_sel", 32'(arr_sel), 32'(sel_of(a)));
        check_eq("w1_we", 32'(arr_we), 0);
        check_eq("w1_wdata", 32'(arr_wdata), 32'(d));
        check_eq("w1_ready", 32'(req_ready), 0);
        tick();
        check_eq("w2_sel", 32'(arr_sel), 32'(sel_of(a)));
        check_eq("w2_we", 32'(arr_we), 1);
        tick();
        check_eq("w3_sel", 32'(arr_sel), 32'(sel_of(a)));
        check_eq("w3_we", 32'(arr_we), 0);
        check_eq("w3_wdata", 32'(arr_wdata), 32'(d));
        tick();
        check_eq("w4_valid", 32'(resp_valid), 1);
        check_eq("w4_rdata", 32'(resp_rdata), 0);
        check_eq("w4_err", 32'(resp_err), 0);
        check_eq("w4_sel", 32'(arr_sel), 0);
        check_eq("w4_wdata", 32'(arr_wdata), 0);
        tick();
        check_eq("w5_valid", 32'(resp_valid), 0);
        check_eq("w5_ready", 32'(req_ready), 1);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input int hold);
        req_valid  = 1'b1;
        req_op     = 1'b0;
        req_addr   = a;
        resp_ready = (hold == 0);
        check_eq("r_req_ready", 32'(req_ready), 1);
        tick();
        req_valid = 1'b0;
`ifdef MEM_REQ_ADDR_CHECK_EN
        if (32'(a) >= WORDS) begin
            check_eq("r_err_valid", 32'(resp_valid), 1);
            check_eq("r_err_flag", 32'(resp_err), 1);
            check_eq("r_err_rdata", 32'(resp_rdata), 0);
            resp_ready = 1'b1;
            tick();
            check_eq("r_err_done", 32'(resp_valid), 0);
            return;
        end
`endif
        check_eq("r1_sel", 32'(arr_sel), 32'(sel_of(a)));
        check_eq("r1_we", 32'(arr_we), 0);
        tick();
        check_eq("r2_sel", 32'(arr_sel), 32'(sel_of(a)));
        check_eq("r2_we", 32'(arr_we), 0);
        tick();
        check_eq("r3_valid", 32'(resp_valid), 1);
        check_eq("r3_rdata", 32'(resp_rdata), 32'(exp));
        check_eq("r3_err", 32'(resp_err), 0);
        check_eq("r3_sel", 32'(arr_sel), 0);
        check_eq("r3_we", 32'(arr_we), 0);
        // Stalled response: a competing write request must be ignored.
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            req_op    = 1'b1;
            req_addr  = 3'd1;
            req_wdata = 8'h77;
            tick();
            check_eq("rh_valid", 32'(resp_valid), 1);
            check_eq("rh_rdata", 32'(resp_rdata), 32'(exp));
            check_eq("rh_ready", 32'(req_ready), 0);
            check_eq("rh_we", 32'(arr_we), 0);
        end
        req_valid  = 1'b0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        tick();
        check_eq("r4_valid", 32'(resp_valid), 0);
        check_eq("r4_ready", 32'(req_ready), 1);
    endtask

    initial begin
        reset = 1'b1;
        tick();
        tick();
        check_eq("rst_sel", 32'(arr_sel), 0);
        check_eq("rst_we", 32'(arr_we), 0);
        check_eq("rst_wdata", 32'(arr_wdata), 0);
        check_eq("rst_valid", 32'(resp_valid), 0);
        check_eq("rst_rdata", 32'(resp_rdata), 0);
        check_eq("rst_err", 32'(resp_err), 0);
        check_eq("rst_ready", 32'(req_ready), 0);
        reset = 1'b0;
        tick();
        check_eq("post_rst_ready", 32'(req_ready), 1);

        do_write(3'd2, 8'hA5);
        do_read(3'd2, 8'hA5, 0);
        do_write(3'd0, 8'h3C);
        do_write(3'd5, 8'hFF);
        do_read(3'd0, 8'h3C, 0);
        do_read(3'd5, 8'hFF, 0);
        do_read(3'd2, 8'hA5, 4);
        do_read(3'd1, 8'h00, 0);

        // Reset while the write enable is high.
        req_valid = 1'b1;
        req_op    = 1'b1;
        req_addr  = 3'd3;
        req_wdata = 8'h5A;
        tick();
        req_valid = 1'b0;
        tick();
        check_eq("rp_we_before", 32'(arr_we), 1);
        reset = 1'b1;
        tick();
        check_eq("rp_we", 32'(arr_we), 0);
        check_eq("rp_sel", 32'(arr_sel), 0);
        check_eq("rp_valid", 32'(resp_valid), 0);
        check_eq("rp_ready_in_rst", 32'(req_ready), 0);
        reset = 1'b0;
        tick();
        check_eq("rp_ready", 32'(req_ready), 1);
        check_eq("rp_valid_after", 32'(resp_valid), 0);
        tick();
        check_eq("rp_no_resp", 32'(resp_valid), 0);

        do_write(3'd7, 8'h5A);
        do_read(3'd7, 8'h00, 0);
        do_read(3'd0, 8'h3C, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
